uart_cmd_rcv: RTL and testbench

//  Serial-to-command front end; feeds cmd/cmd_rdy into the command controller.

---
 rtl/uart_cmd_rcv.sv | 180 ++++++++++++++++++
 tb/tb_uart_cmd_rcv.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rcv.sv
// 8N1 UART receiver that holds each received byte in cmd with a sticky cmd_rdy flag.
// Optional stop-bit check is compiled in with the FRAMING_CHK_EN macro.
module uart_cmd_rcv #(
  parameter int BAUD_DIV = 2604,
  parameter int CNT_W    = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       clr_cmd_rdy,
  output logic [7:0] cmd,
  output logic       cmd_rdy,
  output logic       rx_busy,
  output logic       ovr,
  output logic       frm_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] baud_cnt_r, baud_cnt_s;
  logic [2:0]       bit_cnt_r, bit_cnt_s;
  logic [7:0]       shreg_r, shreg_s;
  logic             rx_meta_r, rx_sync_r, rx_prev_r;
  logic             accept_s;
  logic [7:0]       cmd_r;
  logic             cmd_rdy_r, rx_busy_r, ovr_r;
`ifdef FRAMING_CHK_EN
  logic             ferr_s;
  logic             frm_err_r;
`endif

  // Two-flop synchronizer plus one delay stage for falling-edge detection; idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Next-state, counter and shift-register logic
  always_comb begin
    state_s    = state_r;
    baud_cnt_s = baud_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    shreg_s    = shreg_r;
    accept_s   = 1'b0;
`ifdef FRAMING_CHK_EN
    ferr_s     = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (rx_prev_r && !rx_sync_r) begin
          state_s    = START;
          baud_cnt_s = HALF_LOAD;
          bit_cnt_s  = 3'd0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_cnt_r == '0) begin
          // A high line at mid start bit was only a glitch
          if (!rx_sync_r) begin
            state_s    = DATA;
            baud_cnt_s = FULL_LOAD;
          end else begin
            state_s = IDLE;
          end
        end else begin
          baud_cnt_s = baud_cnt_r - CNT_ONE;
        end
      end
      DATA: begin
        if (baud_cnt_r == '0) begin
          shreg_s    = {rx_sync_r, shreg_r[7:1]};
          bit_cnt_s  = bit_cnt_r + 3'd1;
          baud_cnt_s = FULL_LOAD;
          if (bit_cnt_r == 3'd7) begin
            state_s = STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          baud_cnt_s = baud_cnt_r - CNT_ONE;
        end
      end
      STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed
        if (baud_cnt_r == '0) begin
          state_s = IDLE;
`ifdef FRAMING_CHK_EN
          if (rx_sync_r) begin
            accept_s = 1'b1;
          end else begin
            ferr_s = 1'b1;
          end
`else
          accept_s = 1'b1;
`endif
        end else begin
          baud_cnt_s = baud_cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      baud_cnt_r <= '0;
      bit_cnt_r  <= 3'd0;
      shreg_r    <= 8'h00;
    end else begin
      state_r    <= state_s;
      baud_cnt_r <= baud_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shreg_r    <= shreg_s;
    end
  end

  // Output registers; a new byte wins over a simultaneous consumer clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r     <= 8'h00;
      cmd_rdy_r <= 1'b0;
      rx_busy_r <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      rx_busy_r <= (state_s != IDLE);
      ovr_r     <= accept_s && cmd_rdy_r && !clr_cmd_rdy;
      if (accept_s) begin
        cmd_r     <= shreg_r;
        cmd_rdy_r <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy_r <= 1'b0;
      end else begin
        cmd_rdy_r <= cmd_rdy_r;
      end
    end
  end

`ifdef FRAMING_CHK_EN
  // Framing-error pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_err_r <= 1'b0;
    end else begin
      frm_err_r <= ferr_s;
    end
  end
  assign frm_err = frm_err_r;
`else
  assign frm_err = 1'b0;
`endif

  assign cmd     = cmd_r;
  assign cmd_rdy = cmd_rdy_r;
  assign rx_busy = rx_busy_r;
  assign ovr     = ovr_r;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Directed bench for uart_cmd_rcv at BAUD_DIV=16; build with FRAMING_CHK_EN to cover the stop-bit check.
module tb_uart_cmd_rcv;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       clr_cmd_rdy = 1'b0;
  logic [7:0] cmd;
  logic       cmd_rdy, rx_busy, ovr, frm_err;

  int checks = 0;
  int fails  = 0;
  int ovr_cnt = 0;
  int ferr_cnt = 0;
  int ovr_base, ferr_base;

  uart_cmd_rcv #(.BAUD_DIV(BD), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .clr_cmd_rdy(clr_cmd_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .rx_busy(rx_busy), .ovr(ovr), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  // Count high cycles of the pulse outputs
  always @(posedge clk) begin
    if (ovr) ovr_cnt <= ovr_cnt + 1;
    if (frm_err) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 160-cycle frame; clr_cmd_rdy is driven high only on iteration clr_at (-1 = never)
  task automatic send_frame(input logic [7:0] b, input logic stop, input int clr_at);
    for (int i = 0; i < 10 * BD; i++) begin
      if (i < BD) rx = 1'b0;
      else if (i < 9 * BD) rx = b[(i / BD) - 1];
      else rx = stop;
      clr_cmd_rdy = (i == clr_at);
      tick(1);
    end
    rx = 1'b1;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
  endtask

  logic [7:0] part;

  initial begin
    // Reset state
    tick(3);
    check("rst_cmd", 32'(cmd), 32'h00);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
    check("rst_rx_busy", 32'(rx_busy), 32'h0);
    check("rst_ovr", 32'(ovr), 32'h0);
    check("rst_frm_err", 32'(frm_err), 32'h0);
    rst_n = 1'b1;
    tick(5);
    check("idle_after_rst", 32'(rx_busy), 32'h0);

    // 1: single byte, then consumer clear
    ovr_base = ovr_cnt;
    send_frame(8'h45, 1'b1, -1);
    check("t1_cmd", 32'(cmd), 32'h45);
    check("t1_cmd_rdy", 32'(cmd_rdy), 32'h1);
    check("t1_ovr_cnt", 32'(ovr_cnt - ovr_base), 32'h0);
    check("t1_busy", 32'(rx_busy), 32'h0);
    pulse_clr();
    check("t1_clr", 32'(cmd_rdy), 32'h0);
    check("t1_cmd_hold", 32'(cmd), 32'h45);

    // 2: short low glitch aborts in START
    tick(5);
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    check("t2_busy_hi", 32'(rx_busy), 32'h1);
    tick(20);
    check("t2_busy_lo", 32'(rx_busy), 32'h0);
    check("t2_cmd", 32'(cmd), 32'h45);
    check("t2_cmd_rdy", 32'(cmd_rdy), 32'h0);

    // 3: back-to-back frames, no clear -> overrun
    ovr_base = ovr_cnt;
    send_frame(8'h45, 1'b1, -1);
    send_frame(8'h00, 1'b1, -1);
    check("t3_cmd", 32'(cmd), 32'h00);
    check("t3_cmd_rdy", 32'(cmd_rdy), 32'h1);
    check("t3_ovr_cnt", 32'(ovr_cnt - ovr_base), 32'h1);
    pulse_clr();
    check("t3_clr", 32'(cmd_rdy), 32'h0);

    // 4: clear coincides with the accept edge; set wins
    tick(5);
    send_frame(8'hC3, 1'b1, 9 * BD + 10);
    check("t4_cmd", 32'(cmd), 32'hC3);
    check("t4_cmd_rdy", 32'(cmd_rdy), 32'h1);
    pulse_clr();
    check("t4_clr", 32'(cmd_rdy), 32'h0);

    // 5: stop bit sampled low
    tick(5);
    ferr_base = ferr_cnt;
    send_frame(8'h81, 1'b0, -1);
    tick(5);
`ifdef FRAMING_CHK_EN
    check("t5_cmd", 32'(cmd), 32'hC3);
    check("t5_cmd_rdy", 32'(cmd_rdy), 32'h0);
    check("t5_ferr_cnt", 32'(ferr_cnt - ferr_base), 32'h1);
`else
    check("t5_cmd", 32'(cmd), 32'h81);
    check("t5_cmd_rdy", 32'(cmd_rdy), 32'h1);
    check("t5_ferr_cnt", 32'(ferr_cnt - ferr_base), 32'h0);
`endif
    check("t5_busy", 32'(rx_busy), 32'h0);

    // 6: reset asserted at data bit 4 of a frame, then a clean frame
    part = 8'h5A;
    for (int i = 0; i < 5 * BD + BD / 2; i++) begin
      if (i < BD) rx = 1'b0;
      else rx = part[(i / BD) - 1];
      tick(1);
    end
    check("t6_busy_mid", 32'(rx_busy), 32'h1);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    check("t6_rst_cmd", 32'(cmd), 32'h00);
    check("t6_rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
    check("t6_rst_busy", 32'(rx_busy), 32'h0);
    check("t6_rst_ovr", 32'(ovr), 32'h0);
    check("t6_rst_ferr", 32'(frm_err), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    ovr_base = ovr_cnt;
    send_frame(8'h3A, 1'b1, -1);
    check("t6_cmd", 32'(cmd), 32'h3A);
    check("t6_cmd_rdy", 32'(cmd_rdy), 32'h1);
    check("t6_ovr_cnt", 32'(ovr_cnt - ovr_base), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
